dadda_mul_arbiter: RTL and testbench
====================================

DADDA_MUL_ARBITER -- requirements
Module: dadda_mul_arbiter

Interface
REQ-001 SHALL have parameter: LAT, default 1, pipeline register stages from grant to result (legal values 1 or 2).
REQ-002 SHALL have port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: RST_N  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: REQ0_VALID, REQ1_VALID  input  1 each  requester operand valid.
REQ-005 SHALL have ports: REQ0_READY, REQ1_READY  output  1 each  operand accepted this cycle.
REQ-006 SHALL have ports: REQ0_A, REQ0_B, REQ1_A, REQ1_B  input  16 each  signed two's-complement operands.
REQ-007 SHALL have port: RSP_VALID  output  1  result valid.
REQ-008 SHALL have port: RSP_READY  input  1  consumer accepts result.
REQ-009 SHALL have port: RSP_ID  output  1  requester index owning RSP_DATA.
REQ-010 SHALL have port: RSP_DATA  output  32  signed product.

Function
REQ-011 SHALL share one dadda16x16 instance between both requesters; at most one operand pair is accepted per cycle.
REQ-012 SHALL accept request i when REQi_VALID and REQi_READY are both high at a rising edge.
REQ-013 SHALL drive REQi_READY = grant_i AND NOT stall, where stall = RSP_VALID AND NOT RSP_READY.
REQ-014 SHALL arbitrate round-robin: only one valid -> grant it; both valid -> grant the requester not granted last; neither valid -> no grant.
REQ-015 SHALL update the last-grant pointer only on an accepted request, never on a stall.
REQ-016 SHALL present the request accepted at edge N on RSP_VALID/RSP_ID/RSP_DATA after edge N+LAT when no stall occurs.
REQ-017 SHALL sustain one accepted request and one result per cycle when RSP_READY stays high.
REQ-018 SHALL freeze the whole pipeline (valid bits, tags, operands, products) while stall is high; RSP_* held stable.
REQ-019 SHALL compute RSP_DATA as the full 32-bit signed product; -32768 * -32768 = 1073741824, no saturation.
REQ-020 SHALL return results in acceptance order; RSP_ID equals the index of the accepted requester.
REQ-021 SHALL treat REQi_A/B as don't-care when REQi_VALID is low; operands are sampled only on acceptance.

Reset
REQ-022 SHALL on RST_N low at a rising edge clear all stage valid bits, RSP_VALID=0, RSP_ID=0, RSP_DATA=0.
REQ-023 SHALL reset the last-grant pointer to 1 so requester 0 wins the first contention.
REQ-024 SHALL discard in-flight products on reset mid-operation; no RSP_VALID in the cycle after RST_N rises.
REQ-025 SHALL hold REQ0_READY=REQ1_READY=0 while RST_N is low.

Configuration
REQ-026 SHALL, with DADDA_ARB_PERF_EN defined, add outputs PERF_GNT0, PERF_GNT1 (16 bits each), counting accepted requests per requester, saturating at 16'hFFFF, cleared by reset.
REQ-027 SHALL, without DADDA_ARB_PERF_EN, omit the PERF ports and counters; all other behaviour is unchanged.

Structure
REQ-028 SHALL place operand width 16, product width 32, requester count 2 and the legal LAT range in a shared package dadda_arb_pkg.
REQ-029 SHALL instantiate dadda16x16 (ports A, B, OUTT) as its only sub-module; arbitration and pipeline logic stay in dadda_mul_arbiter.

Verification
REQ-030 SHALL cover single requester: REQ0 A=100, B=-50 with LAT=1 -> one edge later RSP_VALID=1, RSP_ID=0, RSP_DATA=-5000.
REQ-031 SHALL cover contention after reset: REQ0 (3,4), REQ1 (-32768,-32768) both valid -> results 12 (ID 0), then 1073741824 (ID 1), on consecutive cycles.
REQ-032 SHALL cover streaming: both valid continuously for 8 cycles, RSP_READY=1 -> RSP_ID alternates 0,1,0,1..., one result per cycle.
REQ-033 SHALL cover backpressure: RSP_READY low 3 cycles with RSP_VALID=1 and product 32767*32767 -> RSP_DATA held at 1073676289, both READY=0, no request lost.
REQ-034 SHALL cover reset mid-operation with LAT=2: request accepted, RST_N low one cycle -> RSP_VALID stays 0, next contention grants REQ0.
REQ-035 SHALL cover DADDA_ARB_PERF_EN defined: 5 REQ0 and 3 REQ1 accepts -> PERF_GNT0=5, PERF_GNT1=3; 70000 REQ0 accepts -> PERF_GNT0=65535.

Source files
------------

// File: rtl/dadda_arb_pkg.sv
// rtl/dadda_arb_pkg.sv - shared widths, requester count, legal latency range and Dadda stage heights
package dadda_arb_pkg;
  localparam int OP_W    = 16;
  localparam int PROD_W  = 32;
  localparam int N_REQ   = 2;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 2;

  typedef logic [OP_W-1:0]   operand_t;
  typedef logic [PROD_W-1:0] product_t;

  // Target column height after each reduction stage (Dadda sequence 13,9,6,4,3,2)
  function automatic int dadda_height(input int stage);
    case (stage)
      0:       return 13;
      1:       return 9;
      2:       return 6;
      3:       return 4;
      4:       return 3;
      default: return 2;
    endcase
  endfunction
endpackage

// File: rtl/dadda16x16.sv
// rtl/dadda16x16.sv - combinational signed 16x16 multiplier, Baugh-Wooley partial products
// reduced by a Dadda tree of full/half adders and a final carry-propagate add.
module dadda16x16
  import dadda_arb_pkg::*;
(
  input  logic [OP_W-1:0]   A,
  input  logic [OP_W-1:0]   B,
  output logic [PROD_W-1:0] OUTT
);
  always_comb begin : p_tree
    logic [PROD_W-1:0] cur [PROD_W];
    logic [PROD_W-1:0] nxt [PROD_W];
    int                h   [PROD_W];
    int                nh  [PROD_W];
    logic [PROD_W-1:0] row0, row1;
    logic              x, y, z, pp;
    logic [4:0]        ci, cn;
    int                k, d, p, col;
    for (int c = 0; c < PROD_W; c++) begin
      cur[c] = '0;
      nxt[c] = '0;
      h[c]   = 0;
      nh[c]  = 0;
    end
    row0 = '0; row1 = '0;
    x = 1'b0; y = 1'b0; z = 1'b0; pp = 1'b0;
    ci = '0; cn = '0; k = 0; d = 0; p = 0; col = 0;

    // Sign-row cross terms are inverted; constant ones at columns OP_W and PROD_W-1 fix the sign
    for (int i = 0; i < OP_W; i++) begin
      for (int j = 0; j < OP_W; j++) begin
        pp = A[j[3:0]] & B[i[3:0]];
        if ((i == OP_W-1) != (j == OP_W-1)) pp = ~pp;
        col = i + j;
        p = h[col[4:0]];
        cur[col[4:0]][p[4:0]] = pp;
        h[col[4:0]] = p + 1;
      end
    end
    p = h[OP_W];
    cur[OP_W][p[4:0]] = 1'b1;
    h[OP_W] = p + 1;
    p = h[PROD_W-1];
    cur[PROD_W-1][p[4:0]] = 1'b1;
    h[PROD_W-1] = p + 1;

    for (int s = 0; s < 6; s++) begin
      d = dadda_height(s);
      for (int c = 0; c < PROD_W; c++) begin
        ci = c[4:0];
        cn = ci + 5'd1;
        k  = 0;
        for (int it = 0; it < 16; it++) begin
          if (h[ci] - k + nh[ci] > d) begin
            x = cur[ci][k[4:0]];
            y = cur[ci][5'(k + 1)];
            if ((h[ci] - k + nh[ci] - d >= 2) && (h[ci] - k >= 3)) begin
              z = cur[ci][5'(k + 2)];
              k = k + 3;
            end else begin
              z = 1'b0;
              k = k + 2;
            end
            p = nh[ci];
            nxt[ci][p[4:0]] = x ^ y ^ z;
            nh[ci] = p + 1;
            // Carries out of the top column fall off: the product is modulo 2^32
            if (c < PROD_W-1) begin
              p = nh[cn];
              nxt[cn][p[4:0]] = (x & y) | (x & z) | (y & z);
              nh[cn] = p + 1;
            end
          end
        end
        for (int t = 0; t < PROD_W; t++) begin
          if (t >= k && t < h[ci]) begin
            p = nh[ci];
            nxt[ci][p[4:0]] = cur[ci][t[4:0]];
            nh[ci] = p + 1;
          end
        end
      end
      for (int c = 0; c < PROD_W; c++) begin
        cur[c] = nxt[c];
        h[c]   = nh[c];
        nxt[c] = '0;
        nh[c]  = 0;
      end
    end

    for (int c = 0; c < PROD_W; c++) begin
      row0[c] = cur[c][0];
      row1[c] = cur[c][1];
    end
    OUTT = row0 + row1;
  end
endmodule

// File: rtl/dadda_mul_arbiter.sv
// rtl/dadda_mul_arbiter.sv - round-robin two-requester front end sharing one dadda16x16, LAT 1 or 2 stages.
// Defining DADDA_ARB_PERF_EN adds saturating per-requester accept counters PERF_GNT0/PERF_GNT1.
module dadda_mul_arbiter
  import dadda_arb_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ0_VALID,
  input  logic              REQ1_VALID,
  output logic              REQ0_READY,
  output logic              REQ1_READY,
  input  logic [OP_W-1:0]   REQ0_A,
  input  logic [OP_W-1:0]   REQ0_B,
  input  logic [OP_W-1:0]   REQ1_A,
  input  logic [OP_W-1:0]   REQ1_B,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic              RSP_ID,
  output logic [PROD_W-1:0] RSP_DATA
`ifdef DADDA_ARB_PERF_EN
  ,
  output logic [15:0]       PERF_GNT0,
  output logic [15:0]       PERF_GNT1
`endif
);
  localparam int LAT_EFF = (LAT >= LAT_MAX) ? LAT_MAX : LAT_MIN;

  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] take;
  logic             last_gnt;
  logic             stall;
  logic             accept;
  logic             sel_id;
  operand_t         sel_a, sel_b;
  operand_t         mul_a, mul_b;
  product_t         mul_p;
  logic             src_valid;
  logic             src_id;

  // A full output register with no taker freezes every stage
  assign stall      = RSP_VALID & ~RSP_READY;
  assign grant[0]   = REQ0_VALID & (~REQ1_VALID | last_gnt);
  assign grant[1]   = REQ1_VALID & (~REQ0_VALID | ~last_gnt);
  assign REQ0_READY = RST_N & grant[0] & ~stall;
  assign REQ1_READY = RST_N & grant[1] & ~stall;
  assign take       = {REQ1_VALID & REQ1_READY, REQ0_VALID & REQ0_READY};
  assign accept     = |take;
  assign sel_id     = take[1];
  assign sel_a      = sel_id ? REQ1_A : REQ0_A;
  assign sel_b      = sel_id ? REQ1_B : REQ0_B;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      last_gnt <= 1'b1;
    end else if (accept) begin
      last_gnt <= sel_id;
    end
  end

  generate
    if (LAT_EFF == 2) begin : g_lat2
      logic     s1_valid;
      logic     s1_id;
      operand_t s1_a, s1_b;
      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          s1_valid <= 1'b0;
          s1_id    <= 1'b0;
          s1_a     <= '0;
          s1_b     <= '0;
        end else if (!stall) begin
          s1_valid <= accept;
          s1_id    <= sel_id;
          if (accept) begin
            s1_a <= sel_a;
            s1_b <= sel_b;
          end
        end
      end
      assign mul_a     = s1_a;
      assign mul_b     = s1_b;
      assign src_valid = s1_valid;
      assign src_id    = s1_id;
    end else begin : g_lat1
      assign mul_a     = sel_a;
      assign mul_b     = sel_b;
      assign src_valid = accept;
      assign src_id    = sel_id;
    end
  endgenerate

  dadda16x16 u_mul (
    .A    (mul_a),
    .B    (mul_b),
    .OUTT (mul_p)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      RSP_VALID <= 1'b0;
      RSP_ID    <= 1'b0;
      RSP_DATA  <= '0;
    end else if (!stall) begin
      RSP_VALID <= src_valid;
      if (src_valid) begin
        RSP_ID   <= src_id;
        RSP_DATA <= mul_p;
      end
    end
  end

`ifdef DADDA_ARB_PERF_EN
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      PERF_GNT0 <= '0;
      PERF_GNT1 <= '0;
    end else begin
      if (take[0] && PERF_GNT0 != 16'hFFFF) PERF_GNT0 <= PERF_GNT0 + 16'd1;
      if (take[1] && PERF_GNT1 != 16'hFFFF) PERF_GNT1 <= PERF_GNT1 + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dadda_mul_arbiter.sv
// tb/tb_dadda_mul_arbiter.sv - scoreboard bench driving a LAT=1 and a LAT=2 arbiter side by side
// PERF counter checks are built when DADDA_ARB_PERF_EN is defined.
module tb_dadda_mul_arbiter;
  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n      [2];
  logic        req0_valid [2];
  logic        req1_valid [2];
  logic        req0_ready [2];
  logic        req1_ready [2];
  logic [15:0] req0_a     [2];
  logic [15:0] req0_b     [2];
  logic [15:0] req1_a     [2];
  logic [15:0] req1_b     [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic        rsp_id     [2];
  logic [31:0] rsp_data   [2];
`ifdef DADDA_ARB_PERF_EN
  logic [15:0] perf_gnt0  [2];
  logic [15:0] perf_gnt1  [2];
  logic [15:0] m_perf0    [2];
  logic [15:0] m_perf1    [2];
`endif

  logic        mlast [2];
  logic [1:0]  mpv   [2];
  exp_t        sb0[$];
  exp_t        sb1[$];
  int          checks;
  int          errors;

  always #5 clk = ~clk;

  dadda_mul_arbiter #(.LAT(1)) u_dut_l1 (
    .CLK(clk), .RST_N(rst_n[0]),
    .REQ0_VALID(req0_valid[0]), .REQ1_VALID(req1_valid[0]),
    .REQ0_READY(req0_ready[0]), .REQ1_READY(req1_ready[0]),
    .REQ0_A(req0_a[0]), .REQ0_B(req0_b[0]), .REQ1_A(req1_a[0]), .REQ1_B(req1_b[0]),
    .RSP_VALID(rsp_valid[0]), .RSP_READY(rsp_ready[0]), .RSP_ID(rsp_id[0]), .RSP_DATA(rsp_data[0])
`ifdef DADDA_ARB_PERF_EN
    , .PERF_GNT0(perf_gnt0[0]), .PERF_GNT1(perf_gnt1[0])
`endif
  );

  dadda_mul_arbiter #(.LAT(2)) u_dut_l2 (
    .CLK(clk), .RST_N(rst_n[1]),
    .REQ0_VALID(req0_valid[1]), .REQ1_VALID(req1_valid[1]),
    .REQ0_READY(req0_ready[1]), .REQ1_READY(req1_ready[1]),
    .REQ0_A(req0_a[1]), .REQ0_B(req0_b[1]), .REQ1_A(req1_a[1]), .REQ1_B(req1_b[1]),
    .RSP_VALID(rsp_valid[1]), .RSP_READY(rsp_ready[1]), .RSP_ID(rsp_id[1]), .RSP_DATA(rsp_data[1])
`ifdef DADDA_ARB_PERF_EN
    , .PERF_GNT0(perf_gnt0[1]), .PERF_GNT1(perf_gnt1[1])
`endif
  );

  function automatic logic [31:0] prod(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] sa, sb;
    sa = 32'($signed(a));
    sb = 32'($signed(b));
    return sa * sb;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic i, input logic v0, input logic [15:0] a0, input logic [15:0] b0,
                       input logic v1, input logic [15:0] a1, input logic [15:0] b1, input logic rr);
    req0_valid[i] = v0; req0_a[i] = a0; req0_b[i] = b0;
    req1_valid[i] = v1; req1_a[i] = a1; req1_b[i] = b1;
    rsp_ready[i]  = rr;
  endtask

  task automatic step_one(input logic i);
    logic ov, stall, g0, g1, acc;
    exp_t e;
    ov = i ? mpv[i][1] : mpv[i][0];
    chk($sformatf("rsp_valid%0d", i), 32'(rsp_valid[i]), 32'(ov));
    if (ov) begin
      e = i ? sb1[0] : sb0[0];
      chk($sformatf("rsp_id%0d", i), 32'(rsp_id[i]), 32'(e.id));
      chk($sformatf("rsp_data%0d", i), rsp_data[i], e.data);
    end
    stall = ov & ~rsp_ready[i];
    g0 = rst_n[i] & ~stall & req0_valid[i] & (~req1_valid[i] | mlast[i]);
    g1 = rst_n[i] & ~stall & req1_valid[i] & (~req0_valid[i] | ~mlast[i]);
    chk($sformatf("req0_ready%0d", i), 32'(req0_ready[i]), 32'(g0));
    chk($sformatf("req1_ready%0d", i), 32'(req1_ready[i]), 32'(g1));
    acc = g0 | g1;
    if (!rst_n[i]) begin
      mpv[i]   = 2'b00;
      mlast[i] = 1'b1;
      if (i) sb1.delete(); else sb0.delete();
    end else if (!stall) begin
      if (ov) begin
        if (i) void'(sb1.pop_front()); else void'(sb0.pop_front());
      end
      if (acc) begin
        e.id   = g1;
        e.data = g1 ? prod(req1_a[i], req1_b[i]) : prod(req0_a[i], req0_b[i]);
        if (i) sb1.push_back(e); else sb0.push_back(e);
        mlast[i] = g1;
      end
      mpv[i] = {mpv[i][0], acc};
    end
`ifdef DADDA_ARB_PERF_EN
    if (!rst_n[i]) begin
      m_perf0[i] = '0;
      m_perf1[i] = '0;
    end else begin
      if (g0 && m_perf0[i] != 16'hFFFF) m_perf0[i] = m_perf0[i] + 16'd1;
      if (g1 && m_perf1[i] != 16'hFFFF) m_perf1[i] = m_perf1[i] + 16'd1;
    end
`endif
  endtask

  task automatic step();
    #1;
    step_one(1'b0);
    step_one(1'b1);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int n = 0; n < 2; n++) begin
      mlast[n] = 1'b1;
      mpv[n]   = 2'b00;
      rst_n[n] = 1'b0;
`ifdef DADDA_ARB_PERF_EN
      m_perf0[n] = '0;
      m_perf1[n] = '0;
`endif
    end
    drive(1'b0, 1'b1, 16'd1, 16'd2, 1'b1, 16'd3, 16'd4, 1'b1);
    drive(1'b1, 1'b1, 16'd5, 16'd6, 1'b1, 16'd7, 16'd8, 1'b1);
    @(negedge clk);
    #1;
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("reset_valid%0d", n), 32'(rsp_valid[n]), 32'd0);
      chk($sformatf("reset_id%0d", n), 32'(rsp_id[n]), 32'd0);
      chk($sformatf("reset_data%0d", n), rsp_data[n], 32'd0);
    end
    step();
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    drive(1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 1'b1);

    // contention straight after reset: requester 0 first
    drive(1'b0, 1'b1, 16'd3, 16'd4, 1'b1, 16'h8000, 16'h8000, 1'b1);
    step();
    #1 chk("contend_first_id", 32'(rsp_id[0]), 32'd0);
    chk("contend_first_data", rsp_data[0], 32'd12);
    drive(1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 16'h8000, 16'h8000, 1'b1);
    step();
    #1 chk("contend_second_id", 32'(rsp_id[0]), 32'd1);
    chk("contend_second_data", rsp_data[0], 32'd1073741824);
    drive(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 1'b1);
    step();
    step();

    // single requester
    drive(1'b0, 1'b1, 16'd100, 16'(-50), 1'b0, 16'hDEAD, 16'hBEEF, 1'b1);
    step();
    #1 chk("single_data", rsp_data[0], 32'(-5000));
    drive(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 1'b1);
    step();

    // streaming, both requesters valid every cycle
    for (int n = 0; n < 8; n++) begin
      drive(1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'b1, 16'($urandom), 16'($urandom), 1'b1);
      step();
    end
    drive(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 1'b1);
    step();
    step();

    // backpressure with a held result
    drive(1'b0, 1'b1, 16'd32767, 16'd32767, 1'b0, 16'd0, 16'd0, 1'b1);
    step();
    for (int n = 0; n < 3; n++) begin
      drive(1'b0, 1'b1, 16'd5, 16'd6, 1'b1, 16'd7, 16'd8, 1'b0);
      step();
      #1 chk("bp_hold_data", rsp_data[0], 32'd1073676289);
    end
    drive(1'b0, 1'b1, 16'd5, 16'd6, 1'b1, 16'd7, 16'd8, 1'b1);
    step();
    step();
    drive(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 1'b1);
    step();
    step();

    // LAT=2: reset while a product is in flight
    drive(1'b1, 1'b1, 16'd7, 16'(-9), 1'b0, 16'd0, 16'd0, 1'b1);
    step();
    rst_n[1] = 1'b0;
    drive(1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 1'b1);
    step();
    rst_n[1] = 1'b1;
    step();
    #1 chk("lat2_no_valid_after_reset", 32'(rsp_valid[1]), 32'd0);
    drive(1'b1, 1'b1, 16'd11, 16'd12, 1'b1, 16'd13, 16'd14, 1'b1);
    #1 chk("lat2_contend_grant0", 32'(req0_ready[1]), 32'd1);
    step();
    drive(1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 16'd13, 16'd14, 1'b1);
    step();
    drive(1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 1'b1);
    step();
    step();
    step();

    // random traffic and backpressure on both
    for (int n = 0; n < 60; n++) begin
      for (int m = 0; m < 2; m++) begin
        drive(m[0], 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
              1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), $urandom_range(0, 3) != 0);
      end
      step();
    end
    drive(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 1'b1);
    drive(1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 1'b1);
    for (int n = 0; n < 5; n++) step();
    chk("drain_lat1", 32'(sb0.size()), 32'd0);
    chk("drain_lat2", 32'(sb1.size()), 32'd0);

`ifdef DADDA_ARB_PERF_EN
    rst_n[0] = 1'b0;
    step();
    rst_n[0] = 1'b1;
    drive(1'b0, 1'b1, 16'd2, 16'd3, 1'b0, 16'd0, 16'd0, 1'b1);
    for (int n = 0; n < 5; n++) step();
    drive(1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 16'd4, 16'd5, 1'b1);
    for (int n = 0; n < 3; n++) step();
    drive(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 1'b1);
    step();
    #1 chk("perf_gnt0_5", 32'(perf_gnt0[0]), 32'd5);
    chk("perf_gnt1_3", 32'(perf_gnt1[0]), 32'd3);
    chk("perf_model0", 32'(perf_gnt0[0]), 32'(m_perf0[0]));
    drive(1'b0, 1'b1, 16'd1, 16'd1, 1'b0, 16'd0, 16'd0, 1'b1);
    for (int n = 0; n < 70000; n++) step();
    drive(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 1'b1);
    step();
    #1 chk("perf_gnt0_sat", 32'(perf_gnt0[0]), 32'd65535);
    chk("perf_gnt1_hold", 32'(perf_gnt1[0]), 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
